// File: rtl/serial_lookahead_subtractor_pkg.sv
// Shared definitions for the nibble-serial lookahead subtractor: FSM state
// encodings and the fixed per-cycle slice width.
package serial_lookahead_subtractor_pkg;

    localparam int NIB = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_lookahead_subtractor_sub4.sv
// Combinational 4-bit lookahead-borrow unit: d = a - b - bin, computed as the
// lookahead-carry sum a + ~b + ~bin, so borrow-out is the inverted carry-out.
module lookahead_sub4
    import serial_lookahead_subtractor_pkg::*;
(
    input  logic [NIB-1:0] a,
    input  logic [NIB-1:0] b,
    input  logic           bin,
    output logic [NIB-1:0] d,
    output logic           bout
);

    logic [NIB-1:0] nb;
    logic [NIB-1:0] p;
    logic [NIB-1:0] g;
    logic [NIB:0]   c;

    // Every carry is expanded from the generate/propagate terms, so none waits on a ripple.
    always_comb begin
        nb   = ~b;
        p    = a ^ nb;
        g    = a & nb;
        c[0] = ~bin;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        d    = p ^ c[NIB-1:0];
        bout = ~c[NIB];
    end

endmodule

// File: rtl/serial_lookahead_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, one nibble per clock, LSB first,
// with a registered borrow linking consecutive nibbles. One operation in flight.
module serial_lookahead_subtractor
    import serial_lookahead_subtractor_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);

    localparam int NIBS = WIDTH / NIB;
    localparam int IW   = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBS - 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] diff_reg;
    logic [WIDTH-1:0] next_diff;
    logic [IW-1:0]    idx;
    logic             borrow;
    logic             bout_reg;
    logic             zero_reg;
    logic [NIB-1:0]   a_nib;
    logic [NIB-1:0]   b_nib;
    logic [NIB-1:0]   d_nib;
    logic             nib_bout;
    logic             accept;
    logic             last_nib;

    assign accept   = in_valid && in_ready;
    assign last_nib = (idx == LAST_IDX);

    lookahead_sub4 u_sub4 (
        .a    (a_nib),
        .b    (b_nib),
        .bin  (borrow),
        .d    (d_nib),
        .bout (nib_bout)
    );

    // The single lookahead unit is time-multiplexed across nibbles by idx.
    always_comb begin
        a_nib     = a_reg[NIB*int'(idx) +: NIB];
        b_nib     = b_reg[NIB*int'(idx) +: NIB];
        next_diff = diff_reg;
        next_diff[NIB*int'(idx) +: NIB] = d_nib;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)    next_state = CALC;
            CALC:    if (last_nib)  next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Zero is judged on the full result including the nibble landing this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            borrow   <= 1'b0;
            idx      <= '0;
            diff_reg <= '0;
            bout_reg <= 1'b0;
            zero_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg  <= a;
                        b_reg  <= b;
                        borrow <= bin;
                        idx    <= '0;
                    end
                end
                CALC: begin
                    diff_reg <= next_diff;
                    borrow   <= nib_bout;
                    if (last_nib) begin
                        idx      <= '0;
                        bout_reg <= nib_bout;
                        zero_reg <= (next_diff == '0);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff = diff_reg;
    assign bout = bout_reg;
    assign zero = zero_reg;

endmodule

// File: tb/tb_serial_lookahead_subtractor.sv
// Self-checking bench: directed table on a 16-bit build, backpressure and reset
// corner sequences, plus golden-model random runs on 4- and 32-bit builds.
module tb_serial_lookahead_subtractor;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        in_valid = 1'b0, in_ready, bin = 1'b0, out_valid, out_ready = 1'b0, bout, zero;
    logic [15:0] a = '0, b = '0, diff;

    logic        in_valid4 = 1'b0, in_ready4, bin4 = 1'b0, out_valid4, out_ready4 = 1'b0, bout4, zero4;
    logic [3:0]  a4 = '0, b4 = '0, diff4;

    logic        in_valid32 = 1'b0, in_ready32, bin32 = 1'b0, out_valid32, out_ready32 = 1'b0, bout32, zero32;
    logic [31:0] a32 = '0, b32 = '0, diff32;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] diff;
        logic        bout;
        logic        zero;
        string       name;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    serial_lookahead_subtractor #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .zero(zero)
    );

    serial_lookahead_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .bin(bin4), .out_valid(out_valid4), .out_ready(out_ready4),
        .diff(diff4), .bout(bout4), .zero(zero4)
    );

    serial_lookahead_subtractor #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .bin(bin32), .out_valid(out_valid32), .out_ready(out_ready32),
        .diff(diff32), .bout(bout32), .zero(zero32)
    );

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t makeVec(input logic [15:0] va, input logic [15:0] vb, input logic vbin,
                                     input logic [15:0] vd, input logic vbo, input logic vz,
                                     input string vn);
        vec_t v;
        v.a = va; v.b = vb; v.bin = vbin; v.diff = vd; v.bout = vbo; v.zero = vz; v.name = vn;
        return v;
    endfunction

    // One full handshake on the 16-bit build, checking latency, result and return to idle.
    task automatic applyStimulus(input vec_t v);
        int edges;
        edges = 0;
        while (!in_ready && edges < 20) begin
            stepClk();
            edges++;
        end
        checkOutput({v.name, "_in_ready"}, 64'(in_ready), 64'd1);
        a = v.a; b = v.b; bin = v.bin; in_valid = 1'b1;
        stepClk();
        in_valid = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; bin = 1'b1;
        edges = 0;
        while (!out_valid && edges < 20) begin
            stepClk();
            edges++;
        end
        checkOutput({v.name, "_latency"}, 64'(edges), 64'd4);
        checkOutput({v.name, "_diff"}, 64'(diff), 64'(v.diff));
        checkOutput({v.name, "_bout"}, 64'(bout), 64'(v.bout));
        checkOutput({v.name, "_zero"}, 64'(zero), 64'(v.zero));
        out_ready = 1'b1;
        stepClk();
        out_ready = 1'b0;
        checkOutput({v.name, "_drop_valid"}, 64'(out_valid), 64'd0);
        checkOutput({v.name, "_idle_ready"}, 64'(in_ready), 64'd1);
    endtask

    task automatic randOps32(input int n);
        logic [32:0] exp;
        logic [31:0] ra, rb;
        logic        rbin;
        int          w;
        for (int i = 0; i < n; i++) begin
            ra = $urandom; rb = $urandom; rbin = 1'($urandom_range(0, 1));
            if (i % 17 == 0) rb = ra;
            exp = {1'b0, ra} - {1'b0, rb} - 33'(rbin);
            w = 0;
            while (!in_ready32 && w < 20) begin stepClk(); w++; end
            if (!in_ready32) checkOutput("w32_accept_timeout", 64'(in_ready32), 64'd1);
            a32 = ra; b32 = rb; bin32 = rbin; in_valid32 = 1'b1;
            stepClk();
            w = 0;
            while (!out_valid32 && w < 30) begin
                in_valid32 = 1'($urandom_range(0, 1));
                out_ready32 = 1'($urandom_range(0, 1));
                a32 = $urandom; b32 = $urandom;
                stepClk();
                w++;
            end
            in_valid32 = 1'b0;
            out_ready32 = 1'b0;
            repeat ($urandom_range(0, 3)) stepClk();
            checkOutput("w32_valid", 64'(out_valid32), 64'd1);
            checkOutput("w32_result", {30'd0, bout32, zero32, diff32},
                        {30'd0, exp[32], (exp[31:0] == 32'd0), exp[31:0]});
            out_ready32 = 1'b1;
            stepClk();
            out_ready32 = 1'b0;
        end
    endtask

    task automatic randOps4(input int n);
        logic [4:0] exp;
        logic [3:0] ra, rb;
        logic       rbin;
        int         w;
        for (int i = 0; i < n; i++) begin
            ra = 4'($urandom); rb = 4'($urandom); rbin = 1'($urandom_range(0, 1));
            exp = {1'b0, ra} - {1'b0, rb} - 5'(rbin);
            w = 0;
            while (!in_ready4 && w < 20) begin stepClk(); w++; end
            if (!in_ready4) checkOutput("w4_accept_timeout", 64'(in_ready4), 64'd1);
            a4 = ra; b4 = rb; bin4 = rbin; in_valid4 = 1'b1;
            stepClk();
            w = 0;
            while (!out_valid4 && w < 30) begin
                in_valid4 = 1'($urandom_range(0, 1));
                out_ready4 = 1'($urandom_range(0, 1));
                a4 = 4'($urandom); b4 = 4'($urandom);
                stepClk();
                w++;
            end
            in_valid4 = 1'b0;
            out_ready4 = 1'b0;
            checkOutput("w4_latency", 64'(w), 64'd1);
            repeat ($urandom_range(0, 3)) stepClk();
            checkOutput("w4_result", {58'd0, bout4, zero4, diff4},
                        {58'd0, exp[4], (exp[3:0] == 4'd0), exp[3:0]});
            out_ready4 = 1'b1;
            stepClk();
            out_ready4 = 1'b0;
        end
    endtask

    initial begin
        int w;
        vecs.push_back(makeVec(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, "basic"));
        vecs.push_back(makeVec(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, "underflow"));
        vecs.push_back(makeVec(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, "ripple_all"));
        vecs.push_back(makeVec(16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b0, 1'b1, "equal_zero"));
        vecs.push_back(makeVec(16'h0001, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1, "bin_zero"));
        vecs.push_back(makeVec(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, "msb_borrow"));
        vecs.push_back(makeVec(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, "bin_only"));
        vecs.push_back(makeVec(16'h1234, 16'h5678, 1'b0, 16'hBBBC, 1'b1, 1'b0, "mixed_neg"));
        vecs.push_back(makeVec(16'hF0F0, 16'h0F0F, 1'b1, 16'hE1E0, 1'b0, 1'b0, "alt_nibbles"));

        rst = 1'b1;
        stepClk();
        stepClk();
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_diff", 64'(diff), 64'd0);
        checkOutput("reset_bout_zero", {62'd0, bout, zero}, 64'd0);
        rst = 1'b0;
        stepClk();

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Backpressure: result must hold and a stray request must be dropped.
        a = 16'h1234; b = 16'h0234; bin = 1'b0; in_valid = 1'b1;
        stepClk();
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 20) begin stepClk(); w++; end
        for (int c = 0; c < 6; c++) begin
            if (c == 2) begin a = 16'h5555; b = 16'h0000; in_valid = 1'b1; end
            else in_valid = 1'b0;
            checkOutput("stall_hold", {30'd0, out_valid, in_ready, bout, zero, diff},
                        {30'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1000});
            stepClk();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        stepClk();
        out_ready = 1'b0;
        checkOutput("stall_release_ready", 64'(in_ready), 64'd1);
        checkOutput("stall_release_valid", 64'(out_valid), 64'd0);
        checkOutput("stall_diff_kept", 64'(diff), 64'h1000);
        repeat (6) stepClk();
        checkOutput("stray_not_queued", {62'd0, out_valid, in_ready}, 64'd1);

        // Reset on the second CALC edge discards the operation.
        a = 16'hFFFF; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
        stepClk();
        in_valid = 1'b0;
        stepClk();
        rst = 1'b1;
        stepClk();
        rst = 1'b0;
        checkOutput("midreset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midreset_diff", 64'(diff), 64'd0);
        w = 0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid) w++;
            stepClk();
        end
        checkOutput("midreset_no_result", 64'(w), 64'd0);
        applyStimulus(makeVec(16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, "after_reset"));

        randOps4(300);
        randOps32(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
